// File: rtl/patch_result_collector.sv
// patch_result_collector: compacts enabled processor lanes into a counted valid/ready result stream
module patch_result_collector #(
   parameter int DW    = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        p_en,
   input  logic [8*DW-1:0]   lane_data,
   input  logic [CNT_W-1:0]  total_patches,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [2:0]        out_lane,
   output logic              out_last,
   output logic [CNT_W-1:0]  patch_count,
   output logic              done
);

   typedef enum logic [1:0] {EMPTY, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [7:0]         mask_q, mask_d;
   logic [8*DW-1:0]    data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [2:0]         lane;
   logic [7:0]         mask_rest;
   logic [CNT_W-1:0]   cnt_inc;
   logic               hs, complete, cap;

   // Priority search from the top so the lowest pending lane wins
   always_comb begin
      lane = '0;
      for (int i = 7; i >= 0; i--) if (mask_q[i]) lane = 3'(i);
   end

   assign mask_rest   = mask_q & ~(8'd1 << lane);
   assign cnt_inc     = cnt_q + CNT_W'(1);
   assign out_valid   = state_q == DRAIN;
   assign hs          = out_valid & out_ready;
   assign complete    = hs & (total_patches != '0) & (cnt_inc == total_patches);
   assign in_ready    = (state_q == EMPTY) | (hs & (mask_rest == '0) & ~complete);
   assign cap         = in_valid & in_ready;
   assign out_lane    = lane;
   assign out_last    = out_valid & (mask_rest == '0);
   assign out_data    = out_valid ? data_q[lane*DW +: DW] : '0;
   assign patch_count = cnt_q;
   assign done        = done_q;

   // Next state: completion discards the rest of the beat, else capture beats the drain step
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      data_d  = data_q;
      cnt_d   = hs ? cnt_inc : cnt_q;
      done_d  = done_q | complete;
      if (complete) begin
         state_d = DONE;
         mask_d  = '0;
      end else if (cap) begin
         mask_d  = p_en;
         data_d  = lane_data;
         state_d = (p_en != '0) ? DRAIN : EMPTY;
      end else if (hs) begin
         mask_d  = mask_rest;
         state_d = (mask_rest != '0) ? DRAIN : EMPTY;
      end
   end

   // State and holding registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         mask_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_patch_result_collector.sv
// tb_patch_result_collector: randomized scoreboard bench for the lane compaction collector
module tb_patch_result_collector;

   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [7:0]  p_en = '0;
   logic [63:0] lane_data = '0;
   logic [15:0] total_patches = '0;
   logic        in_ready, out_valid, out_last, done;
   logic [7:0]  out_data;
   logic [2:0]  out_lane;
   logic [15:0] patch_count;

   patch_result_collector #(.DW(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .p_en(p_en),
      .lane_data(lane_data), .total_patches(total_patches), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
      .patch_count(patch_count), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [2:0] l;
      logic       last;
   } word_t;

   word_t       q[$];
   int          n_cmp = 0, n_bad = 0;
   bit          rnd = 1'b0;
   logic [15:0] m_cnt = '0, m_pushed = '0;
   bit          m_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected stream is every accepted beat's set lanes in ascending order, cut at the total
   always @(negedge clk) begin
      logic e;
      int   k, n;
      if (rst) begin
         q.delete();
         m_cnt    = '0;
         m_pushed = '0;
         m_done   = 1'b0;
      end else begin
         e = !m_done && (q.size() == 0 || (q.size() == 1 && out_ready && q[0].last &&
             !(total_patches != 0 && m_cnt + 16'd1 == total_patches)));
         check("out_valid", 32'(out_valid), 32'(q.size() != 0));
         check("in_ready", 32'(in_ready), 32'(e));
         check("patch_count", 32'(patch_count), 32'(m_cnt));
         check("done", 32'(done), 32'(m_done));
         if (out_valid && q.size() != 0)
            check("word{data,lane,last}", 32'({out_data, out_lane, out_last}),
                  32'({q[0].d, q[0].l, q[0].last}));
         if (out_valid && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            m_cnt++;
            if (total_patches != 0 && m_cnt == total_patches) m_done = 1'b1;
         end
         if (in_valid && in_ready) begin
            k = 0;
            n = $countones(p_en);
            for (int i = 0; i < 8; i++) if (p_en[i]) begin
               k++;
               if (total_patches == 0 || m_pushed < total_patches) begin
                  q.push_back('{d: lane_data[i*8 +: 8], l: 3'(i), last: (k == n)});
                  m_pushed++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic reset_dut(input logic [15:0] t);
      rst = 1'b1;
      in_valid = 1'b0;
      total_patches = t;
      tick();
      rst = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] m, input logic [63:0] d);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      p_en = m;
      lane_data = d;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
         if (!acc && m_done) break;
      end
      if (!acc && !m_done) begin
         n_bad++;
         $display("FAIL accept_timeout: beat %0h not accepted within %0d cycles", m, n);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      logic [63:0] d;
      logic [4:0]  pat;
      int          w;
      reset_dut(16'd0);
      // Full mask, lane i = i+16
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i + 16);
      send_beat(8'b0011_1111, d);
      idle(8);
      check("full_mask_count", 32'(patch_count), 32'd6);
      // Sparse mask with backpressure 1,0,0,1,1
      send_beat(8'b1000_0011, {$urandom, $urandom});
      pat = 5'b11001;
      for (int i = 0; i < 5; i++) begin
         out_ready = pat[i];
         tick();
      end
      out_ready = 1'b1;
      idle(3);
      check("sparse_count", 32'(patch_count), 32'd9);
      // Zero mask is swallowed
      send_beat(8'h00, {$urandom, $urandom});
      idle(3);
      check("zero_mask_count", 32'(patch_count), 32'd9);
      // Back-to-back beats
      send_beat(8'b0000_1100, {$urandom, $urandom});
      send_beat(8'b1100_0000, {$urandom, $urandom});
      idle(6);
      check("b2b_count", 32'(patch_count), 32'd13);
      // Completion at 5
      reset_dut(16'd5);
      send_beat(8'b0000_0111, {$urandom, $urandom});
      send_beat(8'b0011_1100, {$urandom, $urandom});
      idle(4);
      check("done_done", 32'(done), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_count", 32'(patch_count), 32'd5);
      check("done_out_valid", 32'(out_valid), 32'd0);
      // Reset mid-drain
      reset_dut(16'd0);
      send_beat(8'b1111_0000, {$urandom, $urandom});
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_lane", 32'(out_lane), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_count", 32'(patch_count), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      // Randomized runs, alternately unbounded and with a small total
      for (int r = 0; r < 6; r++) begin
         reset_dut(r[0] ? 16'($urandom_range(8, 30)) : 16'd0);
         rnd = 1'b1;
         for (int b = 0; b < 40 && !m_done; b++) begin
            send_beat(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
                      {$urandom, $urandom});
            idle($urandom_range(0, 2));
         end
         w = 0;
         while (q.size() != 0 && w < 300) begin
            tick();
            w++;
         end
         if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d words still expected", q.size());
         end
         rnd = 1'b0;
         out_ready = 1'b1;
         idle(3);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/patch_result_collector.md
# patch_result_collector

Receive-side counterpart to the processor-enable generator. Each cycle the generator drives an 8-bit lane mask `p_en` to the processor array. This block takes the matching beat of 8 per-lane processor results together with that mask. It compacts the enabled lanes into a sequential stream, lowest lane first, and counts emitted patches against a programmed total. The stream feeds the downstream class-sum/argmax stage through a valid/ready handshake.

## Interface
- `DW`, 8: result width per processor lane
- `CNT_W`, 16: width of the patch counter and of `total_patches`

Ports:
- `clk`  in  1  clock; all logic updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block accepts the input beat this cycle
- `p_en`  in  8  lane-enable mask of the beat; bit i set means lane i holds a valid result
- `lane_data`  in  8*DW  lane i occupies bits [i*DW +: DW]
- `total_patches`  in  CNT_W  number of patches per image; 0 means unbounded; held static while `done`=0
- `out_valid`  out  1  output word present
- `out_ready`  in  1  downstream accepts the output word
- `out_data`  out  DW  result of the presented lane
- `out_lane`  out  3  index of the presented lane
- `out_last`  out  1  presented lane is the last set bit of its beat
- `patch_count`  out  CNT_W  number of output words accepted since reset
- `done`  out  1  sticky; `patch_count` has reached `total_patches`

## Operation
- Holding registers:
  - `mask_q[7:0]` holds the lanes still to emit.
  - `data_q[8*DW-1:0]` holds the captured lane results.
- States:
  - EMPTY: `mask_q`=0.
  - DRAIN: `mask_q`≠0.
  - DONE.
- Input accept: `in_ready` = (state==EMPTY) | (state==DRAIN & out_valid & out_ready & `out_last`). It is 0 in DONE.
- Capture on `in_valid & in_ready`:
  - `mask_q` ← `p_en`, `data_q` ← `lane_data`.
  - If `p_en`=0, the beat is consumed and dropped, and the state stays or returns to EMPTY. No output is produced.
- Presentation in DRAIN:
  - `out_lane` = index of the lowest set bit of `mask_q`.
  - `out_data` = that lane's slice of `data_q`.
  - `out_last` = (`mask_q` has exactly one bit set).
  - `out_valid` = 1.
- On an output handshake (`out_valid & out_ready`):
  - Clear the presented bit in `mask_q`.
  - `patch_count` += 1, wrapping modulo 2^CNT_W.
  - If `mask_q` becomes 0 and no new beat is captured, go to EMPTY.
- `out_data`, `out_lane` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- Completion: if `total_patches`≠0 and a handshake brings `patch_count` to `total_patches`:
  - `done` ← 1 and the state goes to DONE.
  - Remaining bits of `mask_q` are discarded (mask ← 0).
  - `out_valid`=0 from the next cycle.
  - The block leaves DONE only through `rst`.
- Simultaneous last-word handshake and `in_valid`: the new beat is captured in the same cycle, so there is no bubble. This capture is suppressed if that handshake also completes the total, because `in_ready` is gated by the completion condition.
- Reset mid-drain: on the next edge `mask_q`, `data_q` and `patch_count` go to 0, `done` to 0, and the state to EMPTY. The pending beat is lost.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `patch_count`=0, `done`=0.
- Capture at edge t gives `out_valid`=1 in the cycle after t, presenting the lowest enabled lane.
- Sustained throughput with `out_ready`=1 is one word per cycle. A beat with k set bits occupies k cycles.
- The next beat is captured on the same edge as the previous beat's last handshake.
- `done` rises on the edge of the completing handshake. `patch_count` equals `total_patches` in the same cycle that `done` is first seen high.
- `in_ready` and `out_valid` are combinational from state/`mask_q` and `out_ready`. No combinational path exists from `in_valid` to `out_valid`.

## Test plan
- Full mask:
  - Stimulus: `p_en`=8'b00111111 with lane i = i+16, `out_ready`=1.
  - Required: 6 words, lanes 0..5, data 16..21. `out_last` is high only on lane 5. `in_ready` is high in the lane-5 cycle. `patch_count`=6.
- Sparse mask with backpressure:
  - Stimulus: `p_en`=8'b10000011, `out_ready` toggled 1,0,0,1,1.
  - Required: lanes 0,1,7 in order. Outputs are held stable during the stalls. 3 handshakes total.
- Zero mask:
  - Stimulus: `p_en`=0 with `in_valid`=1.
  - Required: beat accepted, `out_valid` stays 0, `patch_count` unchanged.
- Back-to-back beats:
  - Stimulus: 8'b00001100 then 8'b11000000, `in_valid` held, `out_ready`=1.
  - Required: 4 consecutive output cycles with lanes 2,3,6,7 and no gap. The second capture coincides with the lane-3 handshake.
- Completion:
  - Stimulus: `total_patches`=5, beats 8'b00000111 and 8'b00111100.
  - Required: `done` rises on the 5th handshake (lane 3 of the second beat). Lanes 4 and 5 are never emitted. `in_ready`=0 afterwards.
- Reset mid-drain:
  - Stimulus: assert `rst` for one cycle after the 1st of 4 words of 8'b11110000.
  - Required: the next cycle has all outputs at reset values and `patch_count`=0.
